// File: rtl/crc_arbiter_pkg.sv
// Shared definitions for the CRC engine arbiter: widths, timeout default and FSM encoding.
package crc_arbiter_pkg;

    localparam int CRC_W       = 16;
    localparam int DATA_W      = 24;
    localparam int CNT_W       = 11;
    localparam int IDX_W       = 3;
    localparam int TIMEOUT_DEF = 1100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        BUSY    = 3'd2,
        DRAIN   = 3'd3,
        RESP    = 3'd4,
        RECOVER = 3'd5
    } state_t;

endpackage

// File: rtl/crc_arbiter_if.sv
// Requester-side handshake bundle: job requests in, CRC responses out.
interface crc_arbiter_if #(
    parameter int NREQ = 4
);
    import crc_arbiter_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [CRC_W-1:0]       rsp_crc;
    logic                   rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_crc, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_crc, rsp_err
    );

endinterface

// File: rtl/crc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo NREQ.
module rr_arbiter
    import crc_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    int unsigned     pos;
    logic [NREQ-1:0] bit_m;

    // Scan offsets from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        pos       = 0;
        bit_m     = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            pos   = (32'(last_grant) + k) % NREQ;
            bit_m = {{(NREQ-1){1'b0}}, 1'b1} << pos;
            if (|(req & bit_m)) begin
                grant     = bit_m;
                grant_idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/crc_arbiter.sv
// Shares one CRC engine among NREQ requesters: round-robin grant, launch, timeout recovery, response.
module crc_arbiter
    import crc_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    crc_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] eng_data,
    output logic              eng_en,
    output logic              eng_rst,
    input  logic [CRC_W-1:0]  eng_crc,
    input  logic              eng_done,
    output logic              busy,
    output logic [IDX_W-1:0]  grant_idx
);

    state_t            state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [IDX_W-1:0]  last_grant;
    logic [NREQ-1:0]   gnt_vec;
    logic [NREQ-1:0]   win_vec;
    logic [IDX_W-1:0]  win_idx;
    logic              any_req;
    logic              eng_done_q;
    logic              rec_cnt;
    logic [DATA_W-1:0] win_data;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (win_vec),
        .grant_idx  (win_idx),
        .any_req    (any_req)
    );

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDX_W'(i))
                win_data = bus.req_data[DATA_W*i +: DATA_W];
        end
    end

    // Outputs are set on state entry so eng_en/eng_rst/rsp_valid align exactly with their states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_crc   <= '0;
            bus.rsp_err   <= 1'b0;
            eng_data      <= '0;
            eng_en        <= 1'b0;
            eng_rst       <= 1'b1;
            busy          <= 1'b0;
            grant_idx     <= '0;
            last_grant    <= IDX_W'(NREQ-1);
            tmo_cnt       <= '0;
            gnt_vec       <= '0;
            eng_done_q    <= 1'b0;
            rec_cnt       <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            eng_en        <= 1'b0;
            eng_rst       <= 1'b0;
            eng_done_q    <= eng_done;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        bus.req_ready <= win_vec;
                        gnt_vec       <= win_vec;
                        eng_data      <= win_data;
                        grant_idx     <= win_idx;
                        last_grant    <= win_idx;
                        eng_en        <= 1'b1;
                        busy          <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (eng_done && !eng_done_q) begin
                        bus.rsp_crc <= eng_crc;
                        bus.rsp_err <= 1'b0;
                        state       <= DRAIN;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT-1)) begin
                        bus.rsp_crc <= '0;
                        bus.rsp_err <= 1'b1;
                        eng_rst     <= 1'b1;
                        rec_cnt     <= 1'b0;
                        state       <= RECOVER;
                    end
                end
                DRAIN: begin
                    if (!eng_done) begin
                        bus.rsp_valid <= gnt_vec;
                        state         <= RESP;
                    end
                end
                RECOVER: begin
                    if (!rec_cnt) begin
                        rec_cnt <= 1'b1;
                        eng_rst <= 1'b1;
                    end else begin
                        bus.rsp_valid <= gnt_vec;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (|(bus.rsp_ready & gnt_vec)) begin
                        bus.rsp_valid <= '0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_arbiter.sv
// Self-checking bench for crc_arbiter with a behavioural CRC engine stand-in and round-robin model.
module tb_crc_arbiter;
    import crc_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 1100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] eng_data;
    logic              eng_en, eng_rst, busy;
    logic              eng_done = 1'b0;
    logic [CRC_W-1:0]  eng_crc = '0;
    logic [IDX_W-1:0]  grant_idx;

    crc_arbiter_if #(.NREQ(NREQ)) bus();

    crc_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .eng_data  (eng_data),
        .eng_en    (eng_en),
        .eng_rst   (eng_rst),
        .eng_crc   (eng_crc),
        .eng_done  (eng_done),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] crc16(input logic [23:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic int next_winner(input logic [NREQ-1:0] m, input int last);
        for (int off = 1; off <= NREQ; off++) begin
            int c;
            c = (last + off) % NREQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // Engine stand-in: latency eng_lat, done held done_len cycles, junk on eng_crc outside done.
    int          eng_lat = 20;
    int          done_len = 2;
    bit          never_done = 1'b0;
    int          ph = 0;
    int          ecnt = 0;
    logic [23:0] jdata = '0;

    always @(posedge clk) begin
        eng_crc <= 16'($urandom);
        if (eng_rst) begin
            ph       <= 0;
            eng_done <= 1'b0;
        end else begin
            case (ph)
                0: if (eng_en) begin ph <= 1; ecnt <= eng_lat; jdata <= eng_data; end
                1: begin
                    if (ecnt > 0) ecnt <= ecnt - 1;
                    else if (!never_done) begin
                        ph <= 2; ecnt <= done_len - 1; eng_done <= 1'b1; eng_crc <= crc16(jdata);
                    end
                end
                2: begin
                    eng_crc <= crc16(jdata);
                    if (ecnt > 0) ecnt <= ecnt - 1;
                    else begin eng_done <= 1'b0; ph <= 0; end
                end
                default: ph <= 0;
            endcase
        end
    end

    int              cyc = 0, rr_pulses = 0, en_pulses = 0, onehot_err = 0, overlap_err = 0;
    int              stab_err = 0, rst_run = 0, last_rst_run = 0, rst_first_cyc = 0, en_cyc = 0;
    int              rspv_rises = 0, rspv_cyc = 0, done_cyc = 0;
    logic [NREQ-1:0] rspv_q = '0;
    int              grant_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.req_ready != 0) begin
                rr_pulses++;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grant_q.push_back(i);
            end
            if ($countones(bus.req_ready) > 1 || $countones(bus.rsp_valid) > 1) onehot_err++;
            if (eng_en) begin en_pulses++; en_cyc = cyc; if (ph != 0) overlap_err++; end
            if (ph != 0 && eng_data !== jdata) stab_err++;
            if (eng_rst) begin
                if (rst_run == 0) rst_first_cyc = cyc;
                rst_run++;
            end else if (rst_run > 0) begin
                last_rst_run = rst_run;
                rst_run = 0;
            end
            if (eng_done) done_cyc = cyc;
            if ((bus.rsp_valid & ~rspv_q) != 0) begin rspv_rises++; rspv_cyc = cyc; end
        end
        rspv_q = bus.rsp_valid;
    end

    logic [23:0] data [NREQ];
    int          model_last = NREQ - 1;

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input int i, input logic [23:0] d);
        data[i] = d;
        bus.req_data[24*i +: 24] = d;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_crc"},   bus.rsp_crc, 0);
        check({tag, "_rsp_err"},   bus.rsp_err, 0);
        check({tag, "_eng_data"},  eng_data, 0);
        check({tag, "_eng_en"},    eng_en, 0);
        check({tag, "_eng_rst"},   eng_rst, 1);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_grant_idx"}, grant_idx, 0);
    endtask

    task automatic take_grant(input int w, input logic [23:0] d, input bit drop);
        int n, g;
        n = 0;
        while (grant_q.size() == 0 && n < 3000) begin tick(); n++; end
        check("grant_seen", grant_q.size() != 0, 1);
        if (grant_q.size() == 0) return;
        g = grant_q.pop_front();
        check("grant_order", g, w);
        check("grant_idx", grant_idx, w);
        check("eng_data", eng_data, d);
        check("busy_on_grant", busy, 1);
        if (drop) bus.req_valid[g] = 1'b0;
        model_last = w;
    endtask

    task automatic await_rsp(input int w, input logic [23:0] d, input bit err);
        int n;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[w] = 1'b1;
        n = 0;
        while (bus.rsp_valid == 0 && n < 3000) begin tick(); n++; end
        check("rsp_valid", bus.rsp_valid, oh);
        check("rsp_crc", bus.rsp_crc, err ? 16'h0000 : crc16(d));
        check("rsp_err", bus.rsp_err, err);
    endtask

    task automatic accept(input int w);
        bus.rsp_ready[w] = 1'b1;
        tick();
        bus.rsp_ready[w] = 1'b0;
        check("rsp_release", bus.rsp_valid, 0);
    endtask

    task automatic serve_job(input int w, input bit err, input bit drop);
        take_grant(w, data[w], drop);
        await_rsp(w, data[w], err);
        accept(w);
    endtask

    initial begin
        int w, rr0, en0, rises0, viol;
        logic [NREQ-1:0] newm;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) raise(i, 24'($urandom));

        tick();
        check_reset_vals("por");
        tick();
        rst_n = 1'b1;
        tick();
        check("eng_rst_release", eng_rst, 0);

        // All requesters held high from reset: rotation starts after NREQ-1.
        for (int j = 0; j < 5; j++) begin
            w = next_winner(bus.req_valid, model_last);
            serve_job(w, 1'b0, 1'b0);
        end
        bus.req_valid = '0;
        check("rotation_en_pulses", en_pulses, 5);
        check("rotation_overlap", overlap_err, 0);

        // Single requester, known word.
        rr0 = rr_pulses;
        en0 = en_pulses;
        raise(0, 24'hABCDEF);
        serve_job(0, 1'b0, 1'b1);
        check("single_req_ready_pulses", rr_pulses - rr0, 1);
        check("single_eng_en_pulses", en_pulses - en0, 1);

        // Randomized traffic against the rotation model.
        for (int j = 0; j < 10; j++) begin
            eng_lat  = $urandom_range(3, 40);
            done_len = $urandom_range(1, 5);
            newm = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                if (newm[i] && !bus.req_valid[i]) raise(i, 24'($urandom));
            if (bus.req_valid == 0) raise($urandom_range(0, NREQ - 1), 24'($urandom));
            w = next_winner(bus.req_valid, model_last);
            serve_job(w, 1'b0, 1'b1);
        end
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_valid != 0) begin
                w = next_winner(bus.req_valid, model_last);
                serve_job(w, 1'b0, 1'b1);
            end
        end

        // Engine never finishes: timeout, two-cycle engine reset, error response.
        never_done   = 1'b1;
        last_rst_run = 0;
        raise(2, 24'($urandom));
        serve_job(2, 1'b1, 1'b1);
        check("timeout_rst_len", last_rst_run, 2);
        check("timeout_delay", rst_first_cyc - en_cyc, TIMEOUT + 1);
        never_done = 1'b0;
        eng_lat    = 15;
        done_len   = 2;

        // Response held back: no further grant, non-granted rsp_ready bits ignored.
        raise(1, 24'($urandom));
        raise(2, 24'($urandom));
        w = next_winner(bus.req_valid, model_last);
        check("hold_winner_model", w, 1);
        take_grant(w, data[w], 1'b1);
        await_rsp(1, data[1], 1'b0);
        viol = 0;
        for (int k = 0; k < 50; k++) begin
            bus.rsp_ready = (k % 2 != 0) ? 4'b0101 : 4'b1000;
            tick();
            if (bus.rsp_valid !== 4'b0010 || bus.req_ready !== 4'b0000) viol++;
        end
        bus.rsp_ready = '0;
        check("hold_violations", viol, 0);
        check("hold_no_grant", grant_q.size(), 0);
        accept(1);
        serve_job(2, 1'b0, 1'b1);

        // Long done pulse: one capture, response only after done falls.
        eng_lat  = 10;
        done_len = 4;
        raise(3, 24'($urandom));
        take_grant(3, data[3], 1'b1);
        await_rsp(3, data[3], 1'b0);
        check("drain_gap", rspv_cyc - done_cyc, 2);
        check("drain_done_low", eng_done, 0);
        viol = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.rsp_crc !== crc16(data[3])) viol++;
        end
        check("rsp_crc_stable", viol, 0);
        accept(3);

        // Reset in the middle of a job.
        eng_lat = 30;
        raise(0, 24'($urandom));
        take_grant(0, data[0], 1'b1);
        repeat (15) tick();
        check("midjob_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midjob");
        repeat (3) tick();
        rst_n  = 1'b1;
        rises0 = rspv_rises;
        grant_q.delete();
        model_last = NREQ - 1;
        tick();
        check("midjob_eng_rst_release", eng_rst, 0);
        repeat (50) tick();
        check("midjob_no_stale_rsp", rspv_rises - rises0, 0);
        check("midjob_no_grant", grant_q.size(), 0);
        raise(1, 24'($urandom));
        raise(0, 24'($urandom));
        w = next_winner(bus.req_valid, model_last);
        check("post_reset_winner_model", w, 0);
        serve_job(w, 1'b0, 1'b1);
        serve_job(1, 1'b0, 1'b1);

        check("onehot_errors", onehot_err, 0);
        check("eng_en_overlap", overlap_err, 0);
        check("eng_data_stability", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
